axi_control_slave: RTL and testbench

AXI4-Lite control-register responder on the accelerator side of the `s_axi_control` port driven by the host bridge. It decodes single-beat reads and writes into a Vivado-HLS-style control register (start/done/idle) plus `NUM_ARGS` 32-bit argument registers. It drives the accelerator's `ap_start` and argument buses, and collects its `ap_done`/`ap_idle`/`ap_ready` status.

---
 rtl/axi_control_pkg.sv | 13 +
 rtl/axi_control_slave.sv | 111 +++++++++++
 tb/tb_axi_control_slave.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_control_pkg.sv
// axi_control_pkg: shared types and address map for the accelerator control slave
package axi_control_pkg;
   typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
   localparam int CTRL_ADDR = 'h00;
   localparam int ARG_BASE = 'h10;
   localparam int CTRL_WORD = CTRL_ADDR / 4;
   localparam int ARG_WORD = ARG_BASE / 4;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam int CTRL_START = 0;
   localparam int CTRL_DONE = 1;
   localparam int CTRL_IDLE = 2;
endpackage

// File: rtl/axi_control_slave.sv
// axi_control_slave: AXI4-Lite control/argument register block for an HLS-style accelerator
module axi_control_slave
   import axi_control_pkg::*;
#(
   parameter int HOST_AXI_ADDR_BITS = 6,
   parameter int HOST_AXI_DATA_BITS = 32,
   parameter int HOST_AXI_STRB_BITS = HOST_AXI_DATA_BITS / 8,
   parameter int NUM_ARGS = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic s_axi_control_AWVALID,
   output logic s_axi_control_AWREADY,
   input  logic [HOST_AXI_ADDR_BITS-1:0] s_axi_control_AWADDR,
   input  logic s_axi_control_WVALID,
   output logic s_axi_control_WREADY,
   input  logic [HOST_AXI_DATA_BITS-1:0] s_axi_control_WDATA,
   input  logic [HOST_AXI_STRB_BITS-1:0] s_axi_control_WSTRB,
   output logic s_axi_control_BVALID,
   input  logic s_axi_control_BREADY,
   output logic [1:0] s_axi_control_BRESP,
   input  logic s_axi_control_ARVALID,
   output logic s_axi_control_ARREADY,
   input  logic [HOST_AXI_ADDR_BITS-1:0] s_axi_control_ARADDR,
   output logic s_axi_control_RVALID,
   input  logic s_axi_control_RREADY,
   output logic [HOST_AXI_DATA_BITS-1:0] s_axi_control_RDATA,
   output logic [1:0] s_axi_control_RRESP,
   output logic ap_start,
   input  logic ap_done,
   input  logic ap_idle,
   input  logic ap_ready,
   output logic [NUM_ARGS*32-1:0] args
);
   state_t state;
   logic [HOST_AXI_ADDR_BITS-3:0] waddr;
   logic [7:0] arg_b [NUM_ARGS*4];
   logic [NUM_ARGS-1:0] arg_we;
   logic [HOST_AXI_DATA_BITS-1:0] rd_word;
   logic done, ar_ctrl, rd_ok, wr_ok, wr_fire, start_set;
   int ar_idx, w_idx;
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{s_axi_control_ARADDR[1:0], s_axi_control_AWADDR[1:0]};
   assign s_axi_control_ARREADY = state == IDLE;
   assign s_axi_control_AWREADY = state == IDLE && !s_axi_control_ARVALID;
   assign s_axi_control_WREADY = state == WDATA;
   assign s_axi_control_BVALID = state == WRESP;
   assign s_axi_control_RVALID = state == RDATA;
   always_comb begin
      ar_idx = int'(s_axi_control_ARADDR[HOST_AXI_ADDR_BITS-1:2]) - ARG_WORD;
      w_idx = int'(waddr) - ARG_WORD;
      ar_ctrl = int'(s_axi_control_ARADDR[HOST_AXI_ADDR_BITS-1:2]) == CTRL_WORD;
      rd_ok = ar_ctrl || (ar_idx >= 0 && ar_idx < NUM_ARGS);
      rd_word = '0;
      // a done pulse landing with the CTRL read is reported, not lost
      if (ar_ctrl) begin
         rd_word[CTRL_START] = ap_start;
         rd_word[CTRL_DONE] = done || ap_done;
         rd_word[CTRL_IDLE] = ap_idle;
      end else if (rd_ok)
         rd_word = args[ar_idx*32 +: 32];
      wr_fire = state == WDATA && s_axi_control_WVALID;
      wr_ok = int'(waddr) == CTRL_WORD || (w_idx >= 0 && w_idx < NUM_ARGS);
      start_set = wr_fire && int'(waddr) == CTRL_WORD && s_axi_control_WSTRB[0] && s_axi_control_WDATA[CTRL_START];
      for (int i = 0; i < NUM_ARGS; i++)
         arg_we[i] = wr_fire && w_idx == i;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         waddr <= '0;
         s_axi_control_RDATA <= '0;
         s_axi_control_RRESP <= RESP_OKAY;
         s_axi_control_BRESP <= RESP_OKAY;
         ap_start <= 1'b0;
         done <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (s_axi_control_ARVALID) begin
                  s_axi_control_RDATA <= rd_word;
                  s_axi_control_RRESP <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                  state <= RDATA;
               end else if (s_axi_control_AWVALID) begin
                  waddr <= s_axi_control_AWADDR[HOST_AXI_ADDR_BITS-1:2];
                  state <= WDATA;
               end
            WDATA:
               if (s_axi_control_WVALID) begin
                  s_axi_control_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                  state <= WRESP;
               end
            WRESP: state <= s_axi_control_BREADY ? IDLE : WRESP;
            RDATA: state <= s_axi_control_RREADY ? IDLE : RDATA;
         endcase
         ap_start <= start_set || (ap_start && !ap_ready);
         done <= ap_done || (done && !(state == IDLE && s_axi_control_ARVALID && ar_ctrl));
      end
   end
   for (genvar i = 0; i < NUM_ARGS; i++) begin : g_arg
      for (genvar b = 0; b < 4; b++) begin : g_byte
         always_ff @(posedge clock) begin
            if (reset)
               arg_b[4*i+b] <= '0;
            else if (arg_we[i] && s_axi_control_WSTRB[b])
               arg_b[4*i+b] <= s_axi_control_WDATA[8*b +: 8];
         end
         assign args[32*i+8*b +: 8] = arg_b[4*i+b];
      end
   end
endmodule

// File: tb/tb_axi_control_slave.sv
// tb_axi_control_slave: table-driven register checks plus handshake corner sequences
module tb_axi_control_slave;
   logic clock = 0, reset = 1;
   logic awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
   logic arvalid = 0, arready, rvalid, rready = 0;
   logic [5:0] awaddr = 0, araddr = 0;
   logic [31:0] wdata = 0, rdata;
   logic [3:0] wstrb = 0;
   logic [1:0] bresp, rresp;
   logic ap_start, ap_done = 0, ap_idle = 1, ap_ready = 0;
   logic [127:0] args;
   logic [31:0] m_args [4];
   int checks = 0, errors = 0;

   typedef struct {
      bit wr;
      logic [5:0] a;
      logic [31:0] d;
      logic [3:0] s;
      bit idle;
      logic [1:0] resp;
      logic [31:0] rd;
   } vec_t;
   vec_t tbl [16];

   axi_control_slave dut (
      .clock(clock), .reset(reset),
      .s_axi_control_AWVALID(awvalid), .s_axi_control_AWREADY(awready), .s_axi_control_AWADDR(awaddr),
      .s_axi_control_WVALID(wvalid), .s_axi_control_WREADY(wready), .s_axi_control_WDATA(wdata),
      .s_axi_control_WSTRB(wstrb), .s_axi_control_BVALID(bvalid), .s_axi_control_BREADY(bready),
      .s_axi_control_BRESP(bresp), .s_axi_control_ARVALID(arvalid), .s_axi_control_ARREADY(arready),
      .s_axi_control_ARADDR(araddr), .s_axi_control_RVALID(rvalid), .s_axi_control_RREADY(rready),
      .s_axi_control_RDATA(rdata), .s_axi_control_RRESP(rresp),
      .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready), .args(args)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout", name);
   endtask

   function automatic logic [127:0] model_args();
      return {m_args[3], m_args[2], m_args[1], m_args[0]};
   endfunction

   task automatic model_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
      int w;
      w = int'(a[5:2]);
      if (w >= 4 && w < 8)
         for (int b = 0; b < 4; b++)
            if (s[b]) m_args[w-4][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit hold_b, output logic [1:0] r);
      int n;
      awaddr = a;
      awvalid = 1;
      n = 0;
      while (!awready && n < 20) begin tick(); n++; end
      if (n == 20) timeout("aw_wait");
      tick();
      awvalid = 0;
      wdata = d;
      wstrb = s;
      wvalid = 1;
      n = 0;
      while (!wready && n < 20) begin tick(); n++; end
      if (n == 20) timeout("w_wait");
      tick();
      wvalid = 0;
      chk("b_latency", 128'(bvalid), 128'(1));
      r = bresp;
      if (!hold_b) begin
         bready = 1;
         tick();
         bready = 0;
      end
   endtask

   task automatic axi_rd(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
      int n;
      araddr = a;
      arvalid = 1;
      n = 0;
      while (!arready && n < 20) begin tick(); n++; end
      if (n == 20) timeout("ar_wait");
      tick();
      arvalid = 0;
      chk("r_latency", 128'(rvalid), 128'(1));
      d = rdata;
      r = rresp;
      rready = 1;
      tick();
      rready = 0;
   endtask

   initial begin
      logic [31:0] d;
      logic [1:0] r;
      tbl[0]  = '{1'b1, 6'h10, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00, 32'h0};
      tbl[1]  = '{1'b0, 6'h10, 32'h0, 4'h0, 1'b1, 2'b00, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 6'h14, 32'hAAAAAAAA, 4'hF, 1'b1, 2'b00, 32'h0};
      tbl[3]  = '{1'b1, 6'h14, 32'h11223344, 4'h3, 1'b1, 2'b00, 32'h0};
      tbl[4]  = '{1'b0, 6'h14, 32'h0, 4'h0, 1'b1, 2'b00, 32'hAAAA3344};
      tbl[5]  = '{1'b0, 6'h3C, 32'h0, 4'h0, 1'b1, 2'b10, 32'h0};
      tbl[6]  = '{1'b1, 6'h3C, 32'h12345678, 4'hF, 1'b1, 2'b10, 32'h0};
      tbl[7]  = '{1'b0, 6'h04, 32'h0, 4'h0, 1'b1, 2'b10, 32'h0};
      tbl[8]  = '{1'b1, 6'h1C, 32'h000000FF, 4'h1, 1'b1, 2'b00, 32'h0};
      tbl[9]  = '{1'b0, 6'h1F, 32'h0, 4'h0, 1'b1, 2'b00, 32'h000000FF};
      tbl[10] = '{1'b1, 6'h18, 32'hCAFEF00D, 4'hC, 1'b1, 2'b00, 32'h0};
      tbl[11] = '{1'b0, 6'h1A, 32'h0, 4'h0, 1'b1, 2'b00, 32'hCAFE0000};
      tbl[12] = '{1'b0, 6'h00, 32'h0, 4'h0, 1'b0, 2'b00, 32'h00000000};
      tbl[13] = '{1'b0, 6'h00, 32'h0, 4'h0, 1'b1, 2'b00, 32'h00000004};
      tbl[14] = '{1'b1, 6'h08, 32'hFFFFFFFF, 4'hF, 1'b1, 2'b10, 32'h0};
      tbl[15] = '{1'b0, 6'h20, 32'h0, 4'h0, 1'b1, 2'b10, 32'h0};
      for (int i = 0; i < 4; i++) m_args[i] = '0;

      repeat (3) tick();
      reset = 0;
      #1;
      chk("rst_arready", 128'(arready), 128'(1));
      chk("rst_awready", 128'(awready), 128'(1));
      chk("rst_valids", 128'({wready, bvalid, rvalid}), 128'(0));
      chk("rst_regs", 128'({rdata, rresp, bresp, ap_start}), 128'(0));
      chk("rst_args", args, 128'(0));

      foreach (tbl[i]) begin
         ap_idle = tbl[i].idle;
         if (tbl[i].wr) begin
            axi_wr(tbl[i].a, tbl[i].d, tbl[i].s, 1'b0, r);
            if (tbl[i].resp == 2'b00) model_write(tbl[i].a, tbl[i].d, tbl[i].s);
            chk($sformatf("vec%0d_bresp", i), 128'(r), 128'(tbl[i].resp));
            chk($sformatf("vec%0d_args", i), args, model_args());
         end else begin
            axi_rd(tbl[i].a, d, r);
            chk($sformatf("vec%0d_rdata", i), 128'(d), 128'(tbl[i].rd));
            chk($sformatf("vec%0d_rresp", i), 128'(r), 128'(tbl[i].resp));
         end
      end
      ap_idle = 1;

      axi_wr(6'h00, 32'h1, 4'h1, 1'b0, r);
      chk("start_set", 128'(ap_start), 128'(1));
      axi_wr(6'h00, 32'h0, 4'hF, 1'b0, r);
      chk("start_write0_keeps", 128'(ap_start), 128'(1));
      ap_ready = 1;
      #1;
      chk("start_before_edge", 128'(ap_start), 128'(1));
      tick();
      ap_ready = 0;
      chk("start_cleared", 128'(ap_start), 128'(0));
      axi_wr(6'h00, 32'h1, 4'hE, 1'b0, r);
      chk("start_strb0_off", 128'(ap_start), 128'(0));

      awaddr = 6'h00;
      awvalid = 1;
      tick();
      awvalid = 0;
      wdata = 32'h1;
      wstrb = 4'h1;
      wvalid = 1;
      ap_ready = 1;
      tick();
      wvalid = 0;
      ap_ready = 0;
      chk("start_set_wins", 128'(ap_start), 128'(1));
      bready = 1;
      tick();
      bready = 0;
      ap_ready = 1;
      tick();
      ap_ready = 0;
      chk("start_cleared2", 128'(ap_start), 128'(0));

      ap_done = 1;
      tick();
      ap_done = 0;
      axi_rd(6'h00, d, r);
      chk("done_read1", 128'(d), 128'(32'h6));
      axi_rd(6'h00, d, r);
      chk("done_read2", 128'(d), 128'(32'h4));

      ap_done = 1;
      araddr = 6'h00;
      arvalid = 1;
      tick();
      ap_done = 0;
      arvalid = 0;
      chk("done_collide_rdata", 128'(rdata), 128'(32'h6));
      rready = 1;
      tick();
      rready = 0;
      axi_rd(6'h00, d, r);
      chk("done_collide_kept", 128'(d), 128'(32'h6));
      axi_rd(6'h00, d, r);
      chk("done_collide_cleared", 128'(d), 128'(32'h4));

      araddr = 6'h10;
      awaddr = 6'h14;
      arvalid = 1;
      awvalid = 1;
      #1;
      chk("coll_arready", 128'(arready), 128'(1));
      chk("coll_awready", 128'(awready), 128'(0));
      tick();
      arvalid = 0;
      chk("coll_rvalid", 128'(rvalid), 128'(1));
      chk("coll_rdata", 128'(rdata), 128'(m_args[0]));
      chk("coll_aw_blocked", 128'({awready, arready}), 128'(0));
      rready = 1;
      tick();
      rready = 0;
      chk("coll_aw_ready", 128'(awready), 128'(1));
      tick();
      awvalid = 0;
      chk("coll_wready", 128'(wready), 128'(1));
      wdata = 32'h00000055;
      wstrb = 4'hF;
      wvalid = 1;
      tick();
      wvalid = 0;
      model_write(6'h14, 32'h00000055, 4'hF);
      chk("coll_bvalid", 128'(bvalid), 128'(1));
      chk("coll_args", args, model_args());
      bready = 1;
      tick();
      bready = 0;

      axi_wr(6'h00, 32'h1, 4'h1, 1'b0, r);
      axi_wr(6'h10, 32'h12345678, 4'hF, 1'b1, r);
      chk("rst_mid_bvalid_before", 128'(bvalid), 128'(1));
      reset = 1;
      tick();
      reset = 0;
      for (int i = 0; i < 4; i++) m_args[i] = '0;
      chk("rst_mid_bvalid", 128'(bvalid), 128'(0));
      chk("rst_mid_args", args, model_args());
      chk("rst_mid_start", 128'(ap_start), 128'(0));
      chk("rst_mid_arready", 128'(arready), 128'(1));
      axi_rd(6'h00, d, r);
      chk("rst_mid_ctrl", 128'(d), 128'(32'h4));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
